seq_divider: RTL
================

// Module: seq_divider
// PURPOSE
//   Parametrised multi-cycle radix-2 restoring divider for the pipeline EX stage.
//   Handles signed (DIV) and unsigned (DIVU) division in one datapath, selected per operation.
//   Busy/done handshake lets the hazard unit stall the pipeline while an operation is in flight.
//   A cancel input aborts an in-flight operation when the pipeline is flushed.
// PARAMETERS
//   WIDTH  32  operand/result width in bits (>=4); iteration count = WIDTH
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   start      in   1      launch request; sampled only while busy=0
//   is_signed  in   1      1=two's-complement divide, 0=unsigned; captured with start
//   a          in   WIDTH  dividend; captured with start
//   b          in   WIDTH  divisor; captured with start
//   cancel     in   1      abort in-flight op; no done, q/r keep previous values
//   busy       out  1      1 while an op is in progress (CALC or FIX)
//   done       out  1      one-cycle pulse: q/r just updated
//   q          out  WIDTH  quotient; holds until next completed op
//   r          out  WIDTH  remainder; holds until next completed op
// BEHAVIOUR
//   Reset (async, any state): FSM=IDLE, busy=0, done=0, q=0, r=0, counter=0, internal regs=0.
//   FSM states:
//     IDLE: start=1 & cancel=0 at edge E0 -> CALC.
//       Latch |a|, |b| (magnitudes if is_signed, raw values otherwise).
//       Latch quotient sign = a[MSB]^b[MSB] and remainder sign = a[MSB] (signed mode only).
//       Latch div0 = (b==0). busy=1 from E0.
//     CALC: one restoring step per cycle.
//       Shift {rem,quo} left 1; trial = rem - |b|; if trial >= 0 (no borrow): rem=trial, quo[0]=1.
//       rem is WIDTH+1 bits wide to hold the borrow. Counter runs WIDTH-1 down to 0.
//       At count 0 -> FIX.
//     FIX: apply signs (negate quo if quotient sign=1, negate rem if remainder sign=1).
//       Write q/r. done=1 for the following cycle. busy=0. -> IDLE.
//   Latency: start edge E0 -> done high after edge E(WIDTH+1); fixed, data-independent.
//     With WIDTH=32, done rises 33 cycles after start is sampled.
//   Back-to-back ops: start is accepted in the same cycle that done=1, since busy=0 then.
//   start while busy=1: ignored; no effect on operands or state.
//   cancel=1 in CALC/FIX -> IDLE next edge, busy=0, done stays 0, q/r unchanged.
//     cancel outranks start in IDLE: no launch.
//   rst mid-operation: immediate abort; all outputs take their reset values.
//   Divide by zero (div0=1): runs the full latency; q=0, r=0 in both modes; done pulses normally.
//   Signed semantics: truncation toward zero; remainder takes the sign of the dividend.
//     Invariant: a == q*b + r for every b != 0.
//   Signed overflow: MIN_INT / -1 -> q=MIN_INT (wraps), r=0; no exception flag.
//   Magnitude of MIN_INT is 2^(WIDTH-1), held as an unsigned WIDTH-bit value (no overflow).
//   Unsigned mode: no sign fix-up; both operand MSBs are treated as data.
// TESTING  (WIDTH=32)
//   unsigned 100/7 -> q=14, r=2, done exactly 33 cycles after start, busy high throughout.
//   signed 0xFFFFFFF9(-7)/2 -> q=0xFFFFFFFD(-3), r=0xFFFFFFFF(-1); 7/-2 -> q=-3, r=1.
//   signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0; unsigned 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
//   b=0, signed and unsigned -> q=0, r=0, done at cycle 33; start pulsed mid-op -> ignored.
//   Back-to-back: start on the done cycle -> second done 33 cycles later, correct results.
//   cancel at cycle 10 -> no done, q/r keep prior values; rst at cycle 20 -> busy=0, q=r=0 at once.

Source files
------------

// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle between the EX-stage sequencer and the divider.
// The master drives operands and control; the slave (divider) returns status and results.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic             cancel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;

    modport master (
        output start, is_signed, cancel, a, b,
        input  busy, done, q, r
    );

    modport slave (
        input  start, is_signed, cancel, a, b,
        output busy, done, q, r
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider, signed or unsigned per operation, with a
// fixed WIDTH+1 cycle latency, busy/done handshake and flush cancel.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] b_mag;
    logic             q_neg;
    logic             r_neg;
    logic             div0;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic             done_reg;

    logic             launch;
    logic             step;
    logic             finish;
    logic [WIDTH-1:0] a_mag_in;
    logic [WIDTH-1:0] b_mag_in;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign bus.busy = (state != IDLE);
    assign bus.done = done_reg;
    assign bus.q    = q_reg;
    assign bus.r    = r_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.cancel) begin
                    launch     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (bus.cancel) begin
                    state_next = IDLE;
                end else begin
                    step = 1'b1;
                    if (count == '0) begin
                        state_next = FIX;
                    end
                end
            end
            FIX: begin
                state_next = IDLE;
                finish     = !bus.cancel;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand magnitudes; MIN_INT negates to itself, which is its correct unsigned magnitude.
    always_comb begin
        a_mag_in = bus.a;
        b_mag_in = bus.b;
        if (bus.is_signed && bus.a[WIDTH-1]) begin
            a_mag_in = -bus.a;
        end
        if (bus.is_signed && bus.b[WIDTH-1]) begin
            b_mag_in = -bus.b;
        end
    end

    // One restoring step: the extra top bit of diff is the borrow of the trial subtract.
    always_comb begin
        shifted  = {rem[WIDTH-1:0], quo[WIDTH-1]};
        diff     = {1'b0, shifted} - {2'b00, b_mag};
        rem_step = shifted;
        quo_step = {quo[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH+1]) begin
            rem_step    = diff[WIDTH:0];
            quo_step[0] = 1'b1;
        end
    end

    always_comb begin
        q_fix = q_neg ? -quo : quo;
        r_fix = r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
        if (div0) begin
            q_fix = '0;
            r_fix = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            rem      <= '0;
            quo      <= '0;
            b_mag    <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            div0     <= 1'b0;
            q_reg    <= '0;
            r_reg    <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (launch) begin
                count <= CW'(WIDTH - 1);
                rem   <= '0;
                quo   <= a_mag_in;
                b_mag <= b_mag_in;
                q_neg <= bus.is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                r_neg <= bus.is_signed && bus.a[WIDTH-1];
                div0  <= (bus.b == '0);
            end else if (step) begin
                rem <= rem_step;
                quo <= quo_step;
                if (count != '0) begin
                    count <= count - CW'(1);
                end
            end else if (finish) begin
                q_reg    <= q_fix;
                r_reg    <= r_fix;
                done_reg <= 1'b1;
            end
        end
    end
endmodule
